// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: encodings, widths, reset/bubble values and small helpers.
package mips_defs;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned TNEW_W = 2;

  localparam logic [5:0]    OP_SPECIAL   = 6'b000000;
  localparam logic [5:0]    FUNCT_MOVZ   = 6'b001010;
  localparam logic [DW-1:0] RESET_PC     = 32'h0000_3000;
  localparam logic [DW-1:0] BUBBLE_INSTR = 32'h0000_0000;

  // Decode helper for stages that only see the raw instruction word.
  function automatic logic is_movz_instr(input logic [DW-1:0] instr);
    return (instr[31:26] == OP_SPECIAL) && (instr[5:0] == FUNCT_MOVZ);
  endfunction

  // Saturating one-stage decrement of a hazard-unit Tnew value.
  function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] tnew);
    return (tnew == '0) ? '0 : tnew - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/movz_wr_gate.sv
// Conditional-writeback gate: cancels a register write for failed MOVZ, $0 targets or non-writers.
module movz_wr_gate
  import mips_defs::*;
#(
  parameter int unsigned A_W = AW
) (
  input  logic           is_movz,
  input  logic           movz_zero,
  input  logic           reg_write,
  input  logic [A_W-1:0] a3,
  output logic           kill,
  output logic [A_W-1:0] a3_eff,
  output logic           we_eff
);

  // A cancelled write shows up as a3 == 0 so the hazard unit never forwards from it.
  always_comb begin
    kill   = (is_movz && !movz_zero) || (a3 == '0) || !reg_write;
    we_eff = !kill;
    a3_eff = kill ? '0 : a3;
  end

endmodule

// File: rtl/ex_mem_movz_reg.sv
// EX/MEM pipeline register with MOVZ write cancel, Tnew aging, stall hold and flush bubble.
module ex_mem_movz_reg
  import mips_defs::*;
#(
  parameter int unsigned   D_W      = DW,
  parameter int unsigned   A_W      = AW,
  parameter int unsigned   T_W      = TNEW_W,
  parameter logic [D_W-1:0] RST_PC  = D_W'(RESET_PC)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  input  logic [D_W-1:0] instr_E,
  input  logic [D_W-1:0] pc_E,
  input  logic [D_W-1:0] alu_out_E,
  input  logic [D_W-1:0] rt_data_E,
  input  logic [A_W-1:0] a3_E,
  input  logic           reg_write_E,
  input  logic           is_movz_E,
  input  logic           movz_zero_E,
  input  logic [T_W-1:0] tnew_E,
  output logic [D_W-1:0] instr_M,
  output logic [D_W-1:0] pc_M,
  output logic [D_W-1:0] pc8_M,
  output logic [D_W-1:0] alu_out_M,
  output logic [D_W-1:0] rt_data_M,
  output logic [A_W-1:0] a3_M,
  output logic           reg_write_M,
  output logic [T_W-1:0] tnew_M
);

  logic           kill;
  logic [A_W-1:0] a3_eff;
  logic           we_eff;

  movz_wr_gate #(.A_W(A_W)) u_gate (
    .is_movz   (is_movz_E),
    .movz_zero (movz_zero_E),
    .reg_write (reg_write_E),
    .a3        (a3_E),
    .kill      (kill),
    .a3_eff    (a3_eff),
    .we_eff    (we_eff)
  );

  // Reset and flush load the same bubble; flush beats a stall.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      instr_M     <= D_W'(BUBBLE_INSTR);
      pc_M        <= RST_PC;
      alu_out_M   <= '0;
      rt_data_M   <= '0;
      a3_M        <= '0;
      reg_write_M <= 1'b0;
      tnew_M      <= '0;
    end else if (en) begin
      instr_M     <= instr_E;
      pc_M        <= pc_E;
      alu_out_M   <= alu_out_E;
      rt_data_M   <= rt_data_E;
      a3_M        <= a3_eff;
      reg_write_M <= we_eff && !kill;
      tnew_M      <= (tnew_E == '0) ? '0 : tnew_E - T_W'(1);
    end
  end

  // Link value wraps modulo 2^D_W.
  assign pc8_M = pc_M + D_W'(8);

endmodule

// File: tb/tb_ex_mem_movz_reg.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_ex_mem_movz_reg;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] instr_E, pc_E, alu_out_E, rt_data_E;
  logic [4:0]  a3_E;
  logic        reg_write_E, is_movz_E, movz_zero_E;
  logic [1:0]  tnew_E;
  logic [31:0] instr_M, pc_M, pc8_M, alu_out_M, rt_data_M;
  logic [4:0]  a3_M;
  logic        reg_write_M;
  logic [1:0]  tnew_M;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_instr, m_pc, m_alu, m_rt;
  int          m_a3, m_tnew;
  bit          m_rw;

  always #5 clk = ~clk;

  ex_mem_movz_reg dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .instr_E(instr_E), .pc_E(pc_E), .alu_out_E(alu_out_E), .rt_data_E(rt_data_E),
    .a3_E(a3_E), .reg_write_E(reg_write_E), .is_movz_E(is_movz_E),
    .movz_zero_E(movz_zero_E), .tnew_E(tnew_E),
    .instr_M(instr_M), .pc_M(pc_M), .pc8_M(pc8_M), .alu_out_M(alu_out_M),
    .rt_data_M(rt_data_M), .a3_M(a3_M), .reg_write_M(reg_write_M), .tnew_M(tnew_M)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Model update from the rules: bubble on reset/clr, hold on !en, else load.
  task automatic model_edge();
    bit write_ok;
    if (reset || clr) begin
      m_instr = 32'h0; m_pc = 32'h3000; m_alu = 32'h0; m_rt = 32'h0;
      m_a3 = 0; m_rw = 0; m_tnew = 0;
    end else if (en) begin
      m_instr = instr_E; m_pc = pc_E; m_alu = alu_out_E; m_rt = rt_data_E;
      write_ok = reg_write_E && (int'(a3_E) != 0) && !(is_movz_E && !movz_zero_E);
      m_rw = write_ok;
      m_a3 = write_ok ? int'(a3_E) : 0;
      m_tnew = (int'(tnew_E) > 0) ? int'(tnew_E) - 1 : 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_instr"}, instr_M, m_instr);
    check({tag, "_pc"},    pc_M, m_pc);
    check({tag, "_pc8"},   pc8_M, m_pc + 32'd8);
    check({tag, "_alu"},   alu_out_M, m_alu);
    check({tag, "_rt"},    rt_data_M, m_rt);
    check({tag, "_a3"},    32'(a3_M), 32'(m_a3));
    check({tag, "_rw"},    32'(reg_write_M), 32'(m_rw));
    check({tag, "_tnew"},  32'(tnew_M), 32'(m_tnew));
  endtask

  // One clock: update model at the edge, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] a3, input logic rw,
                       input logic mz, input logic zero, input logic [1:0] tn);
    instr_E = ins; pc_E = pc; alu_out_E = alu; rt_data_E = rt; a3_E = a3;
    reg_write_E = rw; is_movz_E = mz; movz_zero_E = zero; tnew_E = tn;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b0;
    drive(32'hDEAD_BEEF, 32'h1111_0000, 32'h5, 32'h6, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2);
    @(negedge clk);

    // 1: reset for two cycles
    step(); step();
    check("rst_instr", instr_M, 32'h0);
    check("rst_pc", pc_M, 32'h3000);
    check("rst_pc8", pc8_M, 32'h3008);
    check("rst_rw", 32'(reg_write_M), 32'h0);
    check("rst_a3", 32'(a3_M), 32'h0);
    check("rst_tnew", 32'(tnew_M), 32'h0);
    reset = 1'b0;

    // 2: MOVZ $8,$9,$10 with rt == 0 writes
    drive(32'h012A_400A, 32'h3004, 32'h1234, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 2'd1);
    step();
    check("movz_z_rw", 32'(reg_write_M), 32'h1);
    check("movz_z_a3", 32'(a3_M), 32'd8);
    check("movz_z_alu", alu_out_M, 32'h1234);
    check_all("movz_z");

    // 3: same MOVZ with rt != 0 is cancelled
    movz_zero_E = 1'b0;
    step();
    check("movz_nz_rw", 32'(reg_write_M), 32'h0);
    check("movz_nz_a3", 32'(a3_M), 32'h0);
    check("movz_nz_alu", alu_out_M, 32'h1234);

    // 4: tnew ages once then holds under stall
    drive(32'h0230_4021, 32'h3008, 32'h77, 32'h88, 5'd8, 1'b1, 1'b0, 1'b0, 2'd2);
    step();
    check("tnew_load", 32'(tnew_M), 32'd1);
    en = 1'b0;
    tnew_E = 2'd3; pc_E = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tnew_hold", 32'(tnew_M), 32'd1);
      check("pc_hold", pc_M, 32'h3008);
    end
    en = 1'b1; tnew_E = 2'd0;
    step();
    check("tnew_zero", 32'(tnew_M), 32'd0);

    // 5: clr beats stall
    en = 1'b0; clr = 1'b1;
    step();
    check("flush_instr", instr_M, 32'h0);
    check("flush_pc", pc_M, 32'h3000);
    check_all("flush");
    en = 1'b1; clr = 1'b0;

    // 6: addu to $0 is cancelled; pc8 wraps
    drive(32'h0109_0021, 32'hFFFF_FFF8, 32'h9, 32'hA, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    step();
    check("zero_dst_rw", 32'(reg_write_M), 32'h0);
    check("pc8_wrap", pc8_M, 32'h0);
    check_all("addu0");

    // Reset during stall returns to bubble
    drive(32'h1234_5678, 32'h5000, 32'h1, 32'h2, 5'd4, 1'b1, 1'b0, 1'b0, 2'd2);
    step();
    en = 1'b0; reset = 1'b1;
    step();
    check_all("rst_stall");
    reset = 1'b0; en = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      clr   = ($urandom_range(0, 11) == 0);
      en    = ($urandom_range(0, 3) != 0);
      drive($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) a3_E = 5'd0;
      if ($urandom_range(0, 7) == 0) pc_E = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      step();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
